// File: rtl/tpi_pkg.sv
// tpi_pkg - shared types and register-map helpers for tpi_multiport.
// Optional vectored-priority support is enabled with TPI_PRIORITY_EN.
package tpi_pkg;

   typedef enum logic [1:0] {
      HS_HANDSHAKE = 2'b00,
      HS_PULSE     = 2'b01,
      HS_LOW       = 2'b10,
      HS_HIGH      = 2'b11
   } hs_mode_e;

   // Register offsets; the map grows with the number of ports.
   function automatic int pr_off(input int np, input int k);
      return k % np;
   endfunction

   function automatic int ddr_off(input int np, input int k);
      return np + (k % np);
   endfunction

   function automatic int cr_off(input int np);
      return 2 * np;
   endfunction

   function automatic int ilr_off(input int np);
      return 2 * np + 1;
   endfunction

   function automatic int mr_off(input int np);
      return 2 * np + 2;
   endfunction

   function automatic int edge_off(input int np);
      return 2 * np + 3;
   endfunction

   function automatic int air_off(input int np);
      return 2 * np + 4;
   endfunction

endpackage

// File: rtl/tpi_multiport_if.sv
// tpi_multiport_if - 6509-side register bus of the multiport TPI.
interface tpi_multiport_if #(
   parameter int W  = 8,
   parameter int AW = 4
);
   logic          cs_n;
   logic          rw;
   logic [AW-1:0] rs;
   logic [W-1:0]  db_in;
   logic [W-1:0]  db_out;

   modport master (output cs_n, rw, rs, db_in, input db_out);
   modport slave  (input cs_n, rw, rs, db_in, output db_out);
endinterface

// File: rtl/tpi_irq_prio.sv
// tpi_irq_prio - active-interrupt register for vectored priority mode.
// Holds the one-hot highest pending source until software acknowledges it.
module tpi_irq_prio
   import tpi_pkg::*;
#(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         res_n,
   input  logic         en_i,
   input  logic [N-1:0] pend_i,
   input  logic         clr_i,
   output logic [N-1:0] air_o
);

   logic [N-1:0] air_q, air_d, top;

   // One-hot of the highest-index pending bit.
   always_comb begin
      top = '0;
      for (int i = 0; i < N; i++) begin
         if (pend_i[i]) begin
            top    = '0;
            top[i] = 1'b1;
         end
      end
   end

   // Load only while empty so a later, higher arrival never pre-empts.
   always_comb begin
      air_d = air_q;
      if (clr_i || !en_i)  air_d = '0;
      else if (air_q == '0) air_d = top;
   end

   // AIR register.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) air_q <= '0;
      else        air_q <= air_d;
   end

   assign air_o = air_q;

endmodule

// File: rtl/tpi_multiport.sv
// tpi_multiport - parametrised triport successor: NPORTS I/O ports, edge-latched
// interrupt controller, NHS handshake strobes. Define TPI_PRIORITY_EN to add
// the vectored active-interrupt register (CR.ip / AIR).
module tpi_multiport
   import tpi_pkg::*;
#(
   parameter int W      = 8,
   parameter int NPORTS = 3,
   parameter int NIRQ   = 5,
   parameter int NHS    = 2,
   parameter int PULSE  = 17
) (
   input  logic                clk,
   input  logic                res_n,
   tpi_multiport_if.slave      bus,
   input  logic [NPORTS*W-1:0] port_in,
   output logic [NPORTS*W-1:0] port_out,
   output logic [NPORTS*W-1:0] port_oe,
   input  logic [NIRQ-1:0]     irq_in,
   output logic [NHS-1:0]      hs_out,
   output logic                irq_n
);

   localparam int AW = $clog2(2*NPORTS+5);
   localparam logic [AW-1:0] A_CR   = AW'(cr_off(NPORTS));
   localparam logic [AW-1:0] A_ILR  = AW'(ilr_off(NPORTS));
   localparam logic [AW-1:0] A_MR   = AW'(mr_off(NPORTS));
   localparam logic [AW-1:0] A_EDGE = AW'(edge_off(NPORTS));

   logic                        rd, wr, wr_cr, wr_ilr;
   logic [NPORTS-1:0][W-1:0]    pr_q, ddr_q;
   logic                        mc_q, ip;
   logic [NHS-1:0][1:0]         hsm_q;
   logic [NIRQ-1:0]             ilr_q, ilr_d, mr_q, edge_q, prev_q, edges, clr;
   logic                        prev_vld_q, irq_n_q;
   logic [W-1:0]                rdata, db_q;
   logic [NHS-1:0]              hs_q, hs_d, rd_pr;
   logic [NHS-1:0][5:0]         cnt_q, cnt_d;

   assign rd     = ~bus.cs_n & bus.rw;
   assign wr     = ~bus.cs_n & ~bus.rw;
   assign wr_cr  = wr & (bus.rs == A_CR);
   assign wr_ilr = wr & (bus.rs == A_ILR);

   assign port_out   = pr_q | ~ddr_q;
   assign port_oe    = ddr_q;
   assign bus.db_out = db_q;

   // Edge detection is suppressed until irq_prev holds a real sample.
   assign edges = prev_vld_q ? ((edge_q & ~prev_q & irq_in) | (~edge_q & prev_q & ~irq_in)) : '0;

`ifdef TPI_PRIORITY_EN
   localparam logic [AW-1:0] A_AIR = AW'(air_off(NPORTS));
   logic            ip_q, wr_air;
   logic [NIRQ-1:0] air;

   assign wr_air = wr & (bus.rs == A_AIR);
   assign ip     = ip_q;
   assign irq_n  = ip_q ? ~|air : irq_n_q;

   // Priority-enable bit of CR.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)     ip_q <= 1'b0;
      else if (wr_cr) ip_q <= bus.db_in[1];
   end

   tpi_irq_prio #(.N(NIRQ)) u_prio (
      .clk    (clk),
      .res_n  (res_n),
      .en_i   (ip_q),
      .pend_i (ilr_q & mr_q),
      .clr_i  (wr_air),
      .air_o  (air)
   );
`else
   assign ip    = 1'b0;
   assign irq_n = irq_n_q;
`endif

   // Port-read strobes for the handshake channels.
   always_comb begin
      rd_pr = '0;
      for (int k = 0; k < NHS; k++)
         rd_pr[k] = rd & (bus.rs == AW'(pr_off(NPORTS, k)));
   end

   // Read mux; unimplemented bits and addresses read as ones.
   always_comb begin
      rdata = '1;
      for (int k = 0; k < NPORTS; k++) begin
         if (bus.rs == AW'(pr_off(NPORTS, k)))  rdata = port_in[k*W +: W];
         if (bus.rs == AW'(ddr_off(NPORTS, k))) rdata = ddr_q[k];
      end
      if (bus.rs == A_CR) begin
         rdata[0]         = mc_q;
         rdata[1]         = ip;
         rdata[2 +: 2*NHS] = hsm_q;
      end
      if (bus.rs == A_ILR)  rdata[NIRQ-1:0] = ilr_q;
      if (bus.rs == A_MR)   rdata[NIRQ-1:0] = mr_q;
      if (bus.rs == A_EDGE) rdata[NIRQ-1:0] = edge_q;
`ifdef TPI_PRIORITY_EN
      if (bus.rs == A_AIR)  rdata[NIRQ-1:0] = air;
`endif
   end

   // Latch update: a new edge beats a same-cycle clear; frozen while mc = 0.
   always_comb begin
      clr = '0;
      if (wr_ilr) clr = ~bus.db_in[NIRQ-1:0];
`ifdef TPI_PRIORITY_EN
      if (wr_air) clr = clr | air;
`endif
      ilr_d = ilr_q;
      if (mc_q) ilr_d = (ilr_q & ~clr) | edges;
   end

   // Handshake level and pulse counters; a CR write returns every channel to idle.
   always_comb begin
      hs_d  = hs_q;
      cnt_d = cnt_q;
      for (int k = 0; k < NHS; k++) begin
         if (cnt_q[k] != 6'd0)      cnt_d[k] = cnt_q[k] - 6'd1;
         if (edges[NIRQ-NHS+k])     hs_d[k]  = 1'b1;
         if (rd_pr[k] && mc_q) begin
            if (hsm_q[k] == HS_HANDSHAKE) hs_d[k]  = 1'b0;
            if (hsm_q[k] == HS_PULSE)     cnt_d[k] = 6'(PULSE);
         end
         if (wr_cr) begin
            hs_d[k]  = 1'b1;
            cnt_d[k] = 6'd0;
         end
      end
   end

   // Strobe output per channel mode.
   always_comb begin
      hs_out = '1;
      for (int k = 0; k < NHS; k++) begin
         case (hs_mode_e'(hsm_q[k]))
            HS_HANDSHAKE: hs_out[k] = hs_q[k];
            HS_PULSE:     hs_out[k] = (cnt_q[k] == 6'd0);
            HS_LOW:       hs_out[k] = 1'b0;
            default:      hs_out[k] = 1'b1;
         endcase
      end
   end

   // Register file, read data, interrupt state.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         pr_q       <= '0;
         ddr_q      <= '0;
         mc_q       <= 1'b0;
         hsm_q      <= '0;
         mr_q       <= '0;
         edge_q     <= '0;
         ilr_q      <= '0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         db_q       <= '0;
         irq_n_q    <= 1'b1;
         hs_q       <= '1;
         cnt_q      <= '0;
      end else begin
         if (wr) begin
            for (int k = 0; k < NPORTS; k++) begin
               if (bus.rs == AW'(pr_off(NPORTS, k)))  pr_q[k]  <= bus.db_in;
               if (bus.rs == AW'(ddr_off(NPORTS, k))) ddr_q[k] <= bus.db_in;
            end
            if (bus.rs == A_CR) begin
               mc_q  <= bus.db_in[0];
               hsm_q <= bus.db_in[2 +: 2*NHS];
            end
            if (bus.rs == A_MR)   mr_q   <= bus.db_in[NIRQ-1:0];
            if (bus.rs == A_EDGE) edge_q <= bus.db_in[NIRQ-1:0];
         end
         if (rd) db_q <= rdata;
         ilr_q      <= ilr_d;
         prev_q     <= irq_in;
         prev_vld_q <= 1'b1;
         irq_n_q    <= ~(mc_q & |(ilr_q & mr_q));
         hs_q       <= hs_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule
